calc_seg7_bcd: RTL and testbench

CALC_SEG7_BCD -- requirements
Module: calc_seg7_bcd

---
 rtl/calc_seg7_pkg.sv | 46 ++++
 rtl/calc_seg7_bcd_if.sv | 19 +
 rtl/calc_seg7_bcd_digit_dec.sv | 35 +++
 rtl/calc_seg7_bcd.sv | 173 +++++++++++++++++
 tb/tb_calc_seg7_bcd.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/calc_seg7_pkg.sv
// Shared types and constants for the arithmetic-to-7-segment display block.
package calc_seg7_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_UPD  = 2'd2
   } state_e;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_MUL = 1'b1
   } op_e;

   // Active-low segment patterns, bit 6 = segment a ... bit 0 = segment g.
   localparam logic [6:0] SEG_D0    = 7'h01;
   localparam logic [6:0] SEG_D1    = 7'h4F;
   localparam logic [6:0] SEG_D2    = 7'h12;
   localparam logic [6:0] SEG_D3    = 7'h06;
   localparam logic [6:0] SEG_D4    = 7'h4C;
   localparam logic [6:0] SEG_D5    = 7'h24;
   localparam logic [6:0] SEG_D6    = 7'h60;
   localparam logic [6:0] SEG_D7    = 7'h0F;
   localparam logic [6:0] SEG_D8    = 7'h00;
   localparam logic [6:0] SEG_D9    = 7'h0C;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h7E;

   // Number of decimal digits needed to hold any unsigned value of 'bits' bits.
   function automatic int bcd_digits(input int bits);
      int v;
      int d;
      v = (32'sd1 <<< bits) - 32'sd1;
      d = 32'sd1;
      for (int i = 0; i < 10; i++) begin
         if (v >= 32'sd10) begin
            v = v / 32'sd10;
            d = d + 32'sd1;
         end else begin
            v = v;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/calc_seg7_bcd_if.sv
// Request/response and display bundle between the requester and calc_seg7_bcd.
interface calc_seg7_bcd_if #(
   parameter int W      = 3,
   parameter int DIGITS = 2
);
   logic                  start;
   logic                  op;
   logic [W-1:0]          a;
   logic [W-1:0]          b;
   logic                  show;
   logic                  busy;
   logic                  done;
   logic                  ovf;
   logic [7*DIGITS-1:0]   seg;
   logic [DIGITS-1:0]     dp;

   modport master (output start, op, a, b, show, input busy, done, ovf, seg, dp);
   modport slave  (input start, op, a, b, show, output busy, done, ovf, seg, dp);
endinterface

// File: rtl/calc_seg7_bcd_digit_dec.sv
// One 7-segment digit decoder; blank has priority over minus, minus over the digit.
module seg7_digit_dec
   import calc_seg7_pkg::*;
(
   input  logic [3:0] i_digit,
   input  logic       i_blank,
   input  logic       i_minus,
   output logic [6:0] o_seg
);

   // Select the active-low pattern for this digit position.
   always_comb begin
      o_seg = SEG_BLANK;
      if (i_blank) begin
         o_seg = SEG_BLANK;
      end else if (i_minus) begin
         o_seg = SEG_MINUS;
      end else begin
         case (i_digit)
            4'd0:    o_seg = SEG_D0;
            4'd1:    o_seg = SEG_D1;
            4'd2:    o_seg = SEG_D2;
            4'd3:    o_seg = SEG_D3;
            4'd4:    o_seg = SEG_D4;
            4'd5:    o_seg = SEG_D5;
            4'd6:    o_seg = SEG_D6;
            4'd7:    o_seg = SEG_D7;
            4'd8:    o_seg = SEG_D8;
            4'd9:    o_seg = SEG_D9;
            default: o_seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/calc_seg7_bcd.sv
// Computes a+b or a*b, converts to BCD by serial double-dabble and drives
// DIGITS 7-segment digits with leading-zero blanking and overflow dashes.
module calc_seg7_bcd
   import calc_seg7_pkg::*;
#(
   parameter int W      = 3,
   parameter int DIGITS = 2,
   parameter int LZB    = 1
)(
   input  logic            clk,
   input  logic            rst_n,
   calc_seg7_bcd_if.slave  bus
);

   localparam int RW = 2 * W;
   localparam int BD = bcd_digits(RW);
   localparam int XD = (BD > DIGITS) ? BD : DIGITS;
   localparam int XW = 4 * XD;
   localparam int CW = $clog2(RW) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(RW - 1);

   state_e              r_state, w_state_nxt;
   logic [CW-1:0]       r_cnt, w_cnt_nxt;
   logic [RW-1:0]       r_bin, w_bin_nxt;
   logic [4*BD-1:0]     r_bcd, w_bcd_nxt, w_bcd_adj;
   logic [4*DIGITS-1:0] r_disp, w_disp_nxt, w_disp_new;
   logic                r_busy, w_busy_nxt;
   logic                r_done, w_done_nxt;
   logic                r_ovf, w_ovf_nxt;
   logic [RW-1:0]       w_a_ext, w_b_ext, w_result;
   logic [XW-1:0]       w_bcd_ext;
   logic                w_hi_nz;
   logic [DIGITS-1:0]   w_blank;
   logic                w_zero_run;
   logic [7*DIGITS-1:0] w_seg;

   // Full-width result of the requested operation, never truncated.
   always_comb begin
      w_a_ext = RW'(bus.a);
      w_b_ext = RW'(bus.b);
      if (op_e'(bus.op) == OP_MUL) begin
         w_result = w_a_ext * w_b_ext;
      end else begin
         w_result = w_a_ext + w_b_ext;
      end
   end

   // Add-3 correction, displayable slice of the BCD and overflow detection.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < BD; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) begin
            w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end else begin
            w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4];
         end
      end
      w_bcd_ext = XW'(r_bcd);
      w_hi_nz   = 1'b0;
      for (int i = DIGITS; i < XD; i++) begin
         if (w_bcd_ext[4*i +: 4] != 4'd0) begin
            w_hi_nz = 1'b1;
         end else begin
            w_hi_nz = w_hi_nz;
         end
      end
      w_disp_new = w_bcd_ext[4*DIGITS-1:0];
   end

   // Next-state and next-register values for the IDLE/CONV/UPD sequencer.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bin_nxt   = r_bin;
      w_bcd_nxt   = r_bcd;
      w_disp_nxt  = r_disp;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_ovf_nxt   = r_ovf;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_state_nxt = ST_CONV;
               w_cnt_nxt   = {CW{1'b0}};
               w_bin_nxt   = w_result;
               w_bcd_nxt   = {(4*BD){1'b0}};
               w_busy_nxt  = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CONV: begin
            w_bcd_nxt = {w_bcd_adj[4*BD-2:0], r_bin[RW-1]};
            w_bin_nxt = {r_bin[RW-2:0], 1'b0};
            if (r_cnt == LAST_CNT) begin
               w_state_nxt = ST_UPD;
            end else begin
               w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         ST_UPD: begin
            w_disp_nxt  = w_disp_new;
            w_ovf_nxt   = w_hi_nz;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = {CW{1'b0}};
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // Sequencer and display state registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= {CW{1'b0}};
         r_bin   <= {RW{1'b0}};
         r_bcd   <= {(4*BD){1'b0}};
         r_disp  <= {(4*DIGITS){1'b0}};
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bin   <= w_bin_nxt;
         r_bcd   <= w_bcd_nxt;
         r_disp  <= w_disp_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   // Leading-zero blanking from the top digit down; ones digit always shown.
   always_comb begin
      w_zero_run = 1'b1;
      w_blank    = {DIGITS{1'b0}};
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if ((i != 0) && (LZB != 32'sd0) && !r_ovf && w_zero_run &&
             (r_disp[4*i +: 4] == 4'd0)) begin
            w_blank[i] = 1'b1;
         end else begin
            w_blank[i] = 1'b0;
         end
         if (r_disp[4*i +: 4] != 4'd0) begin
            w_zero_run = 1'b0;
         end else begin
            w_zero_run = w_zero_run;
         end
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      seg7_digit_dec u_dec (
         .i_digit (r_disp[4*g +: 4]),
         .i_blank (w_blank[g] | ~bus.show),
         .i_minus (r_ovf),
         .o_seg   (w_seg[7*g +: 7])
      );
   end

   assign bus.seg  = w_seg;
   assign bus.dp   = {DIGITS{1'b1}};
   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_calc_seg7_bcd.sv
// Directed scoreboard bench for calc_seg7_bcd: three instances
// (2 digits blanked, 1 digit, 2 digits unblanked) share one stimulus stream.
module tb_calc_seg7_bcd;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_start = 1'b0;
   logic       s_op = 1'b0;
   logic       s_show = 1'b1;
   logic [2:0] s_a = 3'd0;
   logic [2:0] s_b = 3'd0;

   always #5 clk = ~clk;

   calc_seg7_bcd_if #(.W(3), .DIGITS(2)) bus0 ();
   calc_seg7_bcd_if #(.W(3), .DIGITS(1)) bus1 ();
   calc_seg7_bcd_if #(.W(3), .DIGITS(2)) bus2 ();

   assign bus0.start = s_start;  assign bus1.start = s_start;  assign bus2.start = s_start;
   assign bus0.op    = s_op;     assign bus1.op    = s_op;     assign bus2.op    = s_op;
   assign bus0.a     = s_a;      assign bus1.a     = s_a;      assign bus2.a     = s_a;
   assign bus0.b     = s_b;      assign bus1.b     = s_b;      assign bus2.b     = s_b;
   assign bus0.show  = s_show;   assign bus1.show  = s_show;   assign bus2.show  = s_show;

   calc_seg7_bcd #(.W(3), .DIGITS(2), .LZB(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   calc_seg7_bcd #(.W(3), .DIGITS(1), .LZB(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   calc_seg7_bcd #(.W(3), .DIGITS(2), .LZB(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   typedef struct {
      logic [13:0] s0;
      logic [13:0] s1;
      logic [13:0] s2;
      logic        o0;
      logic        o1;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   last_v = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] code_of(input int d);
      case (d)
         0: return 7'h01;  1: return 7'h4F;  2: return 7'h12;  3: return 7'h06;
         4: return 7'h4C;  5: return 7'h24;  6: return 7'h60;  7: return 7'h0F;
         8: return 7'h00;  9: return 7'h0C;
         default: return 7'h7F;
      endcase
   endfunction

   // Reference display pattern for value v on nd digits.
   function automatic logic [13:0] exp_seg(input int v, input int nd, input bit lzb, input bit sh);
      logic [13:0] r;
      logic [6:0]  c;
      int          p;
      int          pw;
      r = 14'h0000;
      p = 1;
      for (int i = 0; i < nd; i++) p = p * 10;
      pw = 1;
      for (int i = 0; i < nd; i++) begin
         if (!sh)                        c = 7'h7F;
         else if (v >= p)                c = 7'h7E;
         else if (lzb && i > 0 && v < pw) c = 7'h7F;
         else                            c = code_of((v / pw) % 10);
         r[7*i +: 7] = c;
         pw = pw * 10;
      end
      return r;
   endfunction

   task automatic push_exp(input int v);
      exp_t e;
      e.s0 = exp_seg(v, 2, 1'b1, 1'b1);
      e.s1 = exp_seg(v, 1, 1'b1, 1'b1);
      e.s2 = exp_seg(v, 2, 1'b0, 1'b1);
      e.o0 = (v >= 100);
      e.o1 = (v >= 10);
      sb.push_back(e);
   endtask

   // One request; operands are scrambled after the start edge, optional re-pulse mid-CONV.
   task automatic do_req(input bit o, input int x, input int y, input bit repulse);
      int   v;
      int   cyc;
      int   busy_cnt;
      int   extra;
      bit   got;
      exp_t e;
      v = o ? x * y : x + y;
      @(negedge clk);
      s_op = o; s_a = x[2:0]; s_b = y[2:0]; s_start = 1'b1;
      push_exp(v);
      cyc = 0; busy_cnt = 0; got = 1'b0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         s_start = 1'b0;
         if (cyc == 1) begin
            s_a  = 3'($urandom_range(0, 7));
            s_b  = 3'($urandom_range(0, 7));
            s_op = ~o;
         end
         if (repulse && cyc == 3) s_start = 1'b1;
         if (bus0.busy) busy_cnt++;
         if (bus0.done) got = 1'b1;
      end
      chk("done_seen", 32'(got), 32'd1);
      if (sb.size() > 0) e = sb.pop_front();
      if (got) begin
         chk("latency", cyc - 1, 7);
         chk("busy_cycles", busy_cnt, 7);
         chk("busy_at_done", 32'(bus0.busy), 32'd0);
         chk("seg_d2", 32'(bus0.seg), 32'(e.s0));
         chk("seg_d1", 32'(bus1.seg), 32'(e.s1));
         chk("seg_nolzb", 32'(bus2.seg), 32'(e.s2));
         chk("ovf_d2", 32'(bus0.ovf), 32'(e.o0));
         chk("ovf_d1", 32'(bus1.ovf), 32'(e.o1));
         last_v = v;
         extra = 0;
         for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus0.done) extra++;
         end
         chk("single_done", extra, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int dn;
      // Reset state
      #12;
      chk("rst_seg_d2", 32'(bus0.seg), 32'(exp_seg(0, 2, 1'b1, 1'b1)));
      chk("rst_seg_d1", 32'(bus1.seg), 32'(exp_seg(0, 1, 1'b1, 1'b1)));
      chk("rst_seg_nolzb", 32'(bus2.seg), 32'(exp_seg(0, 2, 1'b0, 1'b1)));
      chk("rst_busy", 32'(bus0.busy), 32'd0);
      chk("rst_ovf", 32'(bus0.ovf), 32'd0);
      chk("rst_done", 32'(bus0.done), 32'd0);
      chk("dp_off", 32'(bus0.dp), 32'h3);
      @(negedge clk);
      rst_n = 1'b1;

      do_req(1'b0, 7, 5, 1'b0);   // 12
      do_req(1'b1, 7, 7, 1'b0);   // 49
      do_req(1'b0, 0, 0, 1'b0);   // 0, tens blank
      do_req(1'b1, 3, 4, 1'b0);   // 12, single-digit overflow
      do_req(1'b0, 3, 4, 1'b0);   // 7, overflow clears
      do_req(1'b0, 5, 5, 1'b1);   // 10 with ignored re-pulse

      // Reset in the middle of a conversion
      @(negedge clk);
      s_op = 1'b1; s_a = 3'd6; s_b = 3'd6; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("busy_mid_conv", 32'(bus0.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(bus0.busy), 32'd0);
      chk("midrst_seg_d2", 32'(bus0.seg), 32'(exp_seg(0, 2, 1'b1, 1'b1)));
      chk("midrst_seg_d1", 32'(bus1.seg), 32'(exp_seg(0, 1, 1'b1, 1'b1)));
      chk("midrst_ovf_d1", 32'(bus1.ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus0.done) dn++;
      end
      chk("no_done_after_rst", dn, 0);
      chk("idle_after_rst", 32'(bus0.busy), 32'd0);

      do_req(1'b1, 7, 6, 1'b0);   // 42

      // Show toggle while idle
      @(negedge clk);
      s_show = 1'b0;
      #1;
      chk("hide_d2", 32'(bus0.seg), 32'(exp_seg(last_v, 2, 1'b1, 1'b0)));
      chk("hide_d1", 32'(bus1.seg), 32'(exp_seg(last_v, 1, 1'b1, 1'b0)));
      chk("hide_nolzb", 32'(bus2.seg), 32'(exp_seg(last_v, 2, 1'b0, 1'b0)));
      dn = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus0.done) dn++;
      end
      s_show = 1'b1;
      #1;
      chk("restore_d2", 32'(bus0.seg), 32'(exp_seg(last_v, 2, 1'b1, 1'b1)));
      chk("restore_nolzb", 32'(bus2.seg), 32'(exp_seg(last_v, 2, 1'b0, 1'b1)));
      @(negedge clk);
      if (bus0.done) dn++;
      chk("no_done_on_show", dn, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
